// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-client single-port RAM arbiter.
package ram_arb_pkg;
  localparam int MEM_WIDTH_DEF = 16;
  localparam int ADDR_SIZE_DEF = 10;
  localparam int RD_LAT_DEF    = 1;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef logic req_idx_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick; zero latency, no backpressure (caller samples when ready).
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_gnt,
  output req_idx_t   idx,
  output logic       valid
);
  always_comb begin
    idx   = 1'b0;
    valid = |req;
    if (req == 2'b11) idx = ~last_gnt;
    else if (req[1])  idx = 1'b1;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters; write = 2 cycles, read = 3+RD_LAT cycles.
// Requests wait (req held) while busy; parity check built only with RAM_ARB_PARITY_CHK_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*MEM_WIDTH-1:0] req_wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic [MEM_WIDTH-1:0]   rdata,
  output logic                   busy,
  output logic                   par_err,
  output logic [MEM_WIDTH-1:0]   ram_din,
  output logic [ADDR_SIZE-1:0]   ram_addr,
  output logic                   ram_wr_en,
  output logic                   ram_rd_en,
  output logic                   ram_blk_select,
  output logic                   ram_addr_en,
  output logic                   ram_dout_en,
  input  logic [MEM_WIDTH-1:0]   ram_dout,
  input  logic                   ram_parity
);
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  req_idx_t             r_w;
  req_idx_t             r_last_gnt;
  logic                 r_we;
  logic [1:0]           r_gnt;
  logic [1:0]           r_rvalid;
  logic [MEM_WIDTH-1:0] r_rdata;
  logic                 r_busy;
  logic [MEM_WIDTH-1:0] r_ram_din;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic                 r_ram_wr_en;
  logic                 r_ram_rd_en;
  logic                 r_ram_blk_select;
  logic                 r_ram_dout_en;

  req_idx_t             w_idx;
  logic                 w_valid;
  logic                 w_sel_we;
  logic [ADDR_SIZE-1:0] w_sel_addr;
  logic [MEM_WIDTH-1:0] w_sel_wdata;
  logic                 w_last_wait;

  rr_arbiter2 u_arb (
    .req      (req),
    .last_gnt (r_last_gnt),
    .idx      (w_idx),
    .valid    (w_valid)
  );

  assign w_sel_we    = w_idx ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_idx ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
  assign w_sel_wdata = w_idx ? req_wdata[2*MEM_WIDTH-1:MEM_WIDTH] : req_wdata[MEM_WIDTH-1:0];
  assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_w              <= 1'b0;
      r_last_gnt       <= 1'b1;
      r_we             <= 1'b0;
      r_gnt            <= '0;
      r_rvalid         <= '0;
      r_rdata          <= '0;
      r_busy           <= 1'b0;
      r_ram_din        <= '0;
      r_ram_addr       <= '0;
      r_ram_wr_en      <= 1'b0;
      r_ram_rd_en      <= 1'b0;
      r_ram_blk_select <= 1'b0;
      r_ram_dout_en    <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_ram_wr_en <= 1'b0;
      r_ram_rd_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state          <= ISSUE;
            r_w              <= w_idx;
            r_last_gnt       <= w_idx;
            r_we             <= w_sel_we;
            r_ram_addr       <= w_sel_addr;
            r_ram_din        <= w_sel_wdata;
            r_gnt            <= w_idx ? 2'b10 : 2'b01;
            r_ram_blk_select <= 1'b1;
            r_ram_wr_en      <= w_sel_we;
            r_ram_rd_en      <= ~w_sel_we;
            r_ram_dout_en    <= ~w_sel_we;
            r_busy           <= 1'b1;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_state          <= IDLE;
            r_busy           <= 1'b0;
            r_ram_blk_select <= 1'b0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            // RAM output register now holds the word; freeze it by dropping dout_en.
            r_state          <= RESP;
            r_rdata          <= ram_dout;
            r_rvalid         <= r_w ? 2'b10 : 2'b01;
            r_ram_blk_select <= 1'b0;
            r_ram_dout_en    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_PARITY_CHK_EN
  logic r_par_err;
  always_ff @(posedge clk) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= w_last_wait && ((^ram_dout) != ram_parity);
  end
  assign par_err = r_par_err;
`else
  logic w_unused_par;
  assign w_unused_par = ram_parity ^ w_last_wait;
  assign par_err      = 1'b0;
`endif

  assign gnt            = r_gnt;
  assign rvalid         = r_rvalid;
  assign rdata          = r_rdata;
  assign busy           = r_busy;
  assign ram_din        = r_ram_din;
  assign ram_addr       = r_ram_addr;
  assign ram_wr_en      = r_ram_wr_en;
  assign ram_rd_en      = r_ram_rd_en;
  assign ram_blk_select = r_ram_blk_select;
  assign ram_addr_en    = 1'b0;
  assign ram_dout_en    = r_ram_dout_en;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM (RD_LAT=1).
module tb_ram_port_arbiter;
  localparam int MW = 16;
  localparam int AW = 10;
  localparam int RL = 1;
`ifdef RAM_ARB_PARITY_CHK_EN
  localparam bit PAR_EXP = 1'b1;
`else
  localparam bit PAR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*MW-1:0] req_wdata;
  logic [1:0]    gnt, rvalid;
  logic [MW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic          busy, par_err, ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en;
  logic          ram_parity;

  int n_chk = 0;
  int n_fail = 0;

  ram_port_arbiter #(.MEM_WIDTH(MW), .ADDR_SIZE(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .par_err(par_err), .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select), .ram_addr_en(ram_addr_en),
    .ram_dout_en(ram_dout_en), .ram_dout(ram_dout), .ram_parity(ram_parity)
  );

  always #5 clk = ~clk;

  // RAM model: registered output loaded on an enabled read, held otherwise.
  logic [MW-1:0] mem [1024];
  logic [MW-1:0] m_dout = '0;
  bit            bad_par = 1'b0;
  always @(posedge clk) begin
    if (ram_blk_select && ram_wr_en) mem[ram_addr] <= ram_din;
    if (ram_blk_select && ram_rd_en && ram_dout_en) m_dout <= mem[ram_addr];
  end
  assign ram_dout   = m_dout;
  assign ram_parity = (^m_dout) ^ bad_par;

  typedef struct {
    bit          who;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input bit who, input bit we, input logic [9:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp, input bit exp_par);
    logic [1:0] oh;
    oh = who ? 2'b10 : 2'b01;
    @(negedge clk);
    req[who] = 1'b1;
    req_we[who] = we;
    if (who) begin req_addr[19:10] = addr; req_wdata[31:16] = wd; end
    else     begin req_addr[9:0]   = addr; req_wdata[15:0]  = wd; end
    @(negedge clk);
    chk("gnt", gnt, oh);
    chk("busy_issue", busy, 1);
    chk("blk_issue", ram_blk_select, 1);
    chk("wr_en_issue", ram_wr_en, we);
    chk("rd_en_issue", ram_rd_en, !we);
    chk("dout_en_issue", ram_dout_en, !we);
    chk("addr_issue", ram_addr, addr);
    chk("addr_en", ram_addr_en, 0);
    if (we) chk("din_issue", ram_din, wd);
    req[who] = 1'b0;
    if (!we) begin
      for (int k = 0; k < RL; k++) begin
        @(negedge clk);
        chk("wait_ctl", {gnt, rvalid, ram_rd_en, ram_dout_en, ram_blk_select, busy}, 7'b0000111);
      end
      @(negedge clk);
      chk("rvalid", rvalid, oh);
      chk("rdata", rdata, exp);
      chk("par_err", par_err, exp_par);
      chk("resp_ctl", {ram_blk_select, ram_dout_en, busy}, 3'b001);
    end
    @(negedge clk);
    chk("idle_ctl", {busy, gnt, rvalid, ram_wr_en, ram_rd_en, par_err}, 0);
    if (we) chk("mem_write", mem[addr], wd);
    else    chk("rdata_hold", rdata, exp);
  endtask

  initial begin
    int n_g, cyc, last_gc;
    bit exp_w;
    logic [1:0] reinst, prev_oh;

    vt[0] = '{who: 1'b0, we: 1'b1, addr: 10'd7,   wdata: 16'hA5A5, exp: 16'h0000};
    vt[1] = '{who: 1'b1, we: 1'b0, addr: 10'd7,   wdata: 16'h0000, exp: 16'hA5A5};
    vt[2] = '{who: 1'b1, we: 1'b1, addr: 10'h3FF, wdata: 16'h1234, exp: 16'h0000};
    vt[3] = '{who: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 16'h0000, exp: 16'h1234};
    vt[4] = '{who: 1'b0, we: 1'b1, addr: 10'd0,   wdata: 16'hFFFF, exp: 16'h0000};
    vt[5] = '{who: 1'b1, we: 1'b0, addr: 10'd0,   wdata: 16'h0000, exp: 16'hFFFF};
    vt[6] = '{who: 1'b0, we: 1'b0, addr: 10'd7,   wdata: 16'h0000, exp: 16'hA5A5};

    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_ctl", {gnt, rvalid, busy, par_err, ram_wr_en, ram_rd_en, ram_blk_select,
                      ram_addr_en, ram_dout_en}, 0);
      chk("rst_addr_din", {ram_addr, ram_din}, 0);
      chk("rst_rdata", rdata, 0);
      req       = 2'($urandom_range(0, 3));
      req_we    = 2'($urandom_range(0, 3));
      req_addr  = 20'($urandom);
      req_wdata = $urandom;
    end
    req = '0; req_we = '0;
    rst = 1'b0;

    // Contention: both clients keep reading; first tie after reset goes to 0.
    @(negedge clk);
    req = 2'b11; req_we = 2'b00; req_addr = {10'd20, 10'd10};
    n_g = 0; cyc = 0; last_gc = 0; exp_w = 1'b0; reinst = '0; prev_oh = '0;
    while (n_g < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req = req | reinst;
      reinst = '0;
      if (rvalid != 2'b00) chk("cont_rvalid", rvalid, prev_oh);
      if (gnt != 2'b00) begin
        chk("cont_gnt", gnt, exp_w ? 2'b10 : 2'b01);
        if (n_g > 0) chk("cont_gap", cyc - last_gc, 4);
        last_gc = cyc;
        prev_oh = gnt;
        req     = req & ~gnt;
        reinst  = gnt;
        exp_w   = ~exp_w;
        n_g++;
      end
    end
    chk("cont_grants", n_g, 8);
    req = '0;
    repeat (4) @(negedge clk);
    chk("cont_drain", busy, 0);

    for (int i = 0; i < 7; i++)
      do_op(vt[i].who, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, 1'b0);

    // Reset during WAIT drops the read.
    @(negedge clk);
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[9:0] = 10'd7;
    @(negedge clk);
    chk("rmr_gnt", gnt, 2'b01);
    req[0] = 1'b0;
    @(negedge clk);
    chk("rmr_wait", {busy, ram_dout_en, ram_blk_select}, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("rmr_idle", {busy, rvalid, ram_dout_en, ram_blk_select, ram_rd_en}, 0);
    chk("rmr_rdata", rdata, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rmr_no_rvalid", rvalid, 0);
    end
    do_op(1'b0, 1'b0, 10'd7, 16'h0000, 16'hA5A5, 1'b0);

    // Parity: corrupt RAM parity on one read, then a clean read.
    do_op(1'b0, 1'b1, 10'd5, 16'h0001, 16'h0000, 1'b0);
    bad_par = 1'b1;
    do_op(1'b1, 1'b0, 10'd5, 16'h0000, 16'h0001, PAR_EXP);
    bad_par = 1'b0;
    do_op(1'b1, 1'b0, 10'd5, 16'h0000, 16'h0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester controller that shares one `Single_sync_RAM` instance (16-bit × 1024, single port) between two clients. It round-robin arbitrates read and write requests and drives all RAM control pins (`blk_select`, `wr_en`, `rd_en`, `addr_en`, `dout_en`). It sequences each read through the RAM output-register latency and returns data to the winning requester with a one-cycle `rvalid` pulse. It sits between the client logic and the RAM; it is the only driver of the RAM pins.

## Interface
Parameters:
- MEM_WIDTH, 16: data width.
- ADDR_SIZE, 10: address width (depth 2**ADDR_SIZE).
- RD_LAT, 1: cycles from ISSUE until `ram_dout` holds valid read data (range 1–4).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  request per requester, bit i = requester i.
- req_we  in  2  1 = write, 0 = read, per requester.
- req_addr  in  2*ADDR_SIZE  address; requester i occupies slice i.
- req_wdata  in  2*MEM_WIDTH  write data; requester i occupies slice i.
- gnt  out  2  one-cycle grant pulse to the winning requester.
- rvalid  out  2  one-cycle read-data-valid pulse to the requester that issued the read.
- rdata  out  MEM_WIDTH  read data, qualified by `rvalid`.
- busy  out  1  high in every state except IDLE.
- par_err  out  1  parity mismatch, pulses with `rvalid` (see Configuration).
- ram_din  out  MEM_WIDTH  RAM write data.
- ram_addr  out  ADDR_SIZE  RAM address.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_en  out  1  RAM read enable.
- ram_blk_select  out  1  RAM block select.
- ram_addr_en  out  1  RAM address-pipeline enable; held at 0.
- ram_dout_en  out  1  RAM output-register enable.
- ram_dout  in  MEM_WIDTH  RAM read data.
- ram_parity  in  1  RAM `parity_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any `req` bit is set:
  - Pick a winner. If only one bit is set, that requester wins. If both are set, the requester other than `last_gnt` wins.
  - Register the winner's `we`/`addr`/`wdata` into the command register and go to ISSUE.
- ISSUE, one cycle, all outputs driven from registers:
  - `gnt[w]=1`, `ram_blk_select=1`, `ram_addr`/`ram_din` from the command register.
  - Write: `ram_wr_en=1`, then go to IDLE.
  - Read: `ram_rd_en=1`, `ram_dout_en=1`, then go to WAIT.
  - `last_gnt` updates to w.
- WAIT, RD_LAT cycles, counted by a down-counter:
  - `ram_blk_select=1`, `ram_dout_en=1`, `ram_rd_en=0`.
  - In the last WAIT cycle, capture `ram_dout` and `ram_parity`. Then go to RESP.
- RESP, one cycle: `rvalid[w]=1`, `rdata` = captured word. Then go to IDLE.
- Outside ISSUE/WAIT, all RAM enables are 0 and `ram_dout_en=0`, so the RAM output register holds its value.
- Requester handshake: a requester holds `req`/`we`/`addr`/`wdata` until it sees its `gnt`, then deasserts `req` for at least one cycle.
  - Values are sampled only in IDLE.
  - A `req` that drops after sampling is still serviced.
- Only one operation is in flight at a time. Requests arriving in a non-IDLE state wait.
- `rdata` holds its last value between `rvalid` pulses.

## Timing
- Reset values: state IDLE, `gnt=0`, `rvalid=0`, `rdata=0`, `busy=0`, `par_err=0`, all `ram_*` outputs 0, `last_gnt=1` (so requester 0 wins the first tie).
- Reset asserted in any state returns to IDLE on the next edge. An in-flight read is dropped with no `rvalid`.
- Write, request sampled in cycle 0: `gnt` and RAM write in cycle 1, IDLE in cycle 2. Maximum rate is one write per 2 cycles.
- Read, request sampled in cycle 0: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, `rvalid` in cycle 2+RD_LAT. With RD_LAT=1, `rvalid` is in cycle 3 and the next grant is possible in cycle 5.
- Back-to-back ties alternate the grant: 0, 1, 0, 1, ...

## Configuration
- Macro `RAM_ARB_PARITY_CHK_EN`.
- Defined:
  - `par_err` = (^captured `rdata`) != captured `ram_parity`.
  - It is registered and asserted only in the RESP cycle.
- Undefined: `par_err` is tied to 0 and no parity logic or parity capture register is built.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - default MEM_WIDTH/ADDR_SIZE/RD_LAT constants;
  - the requester-index type.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `req` and `last_gnt`. It outputs the winner index and a `valid` flag.

## Test plan
- Reset: hold `rst` for 5 cycles with random `req` → `gnt`, `rvalid`, all `ram_*` outputs and `busy` stay 0.
- Single write: requester 0 writes 16'hA5A5 to address 10'd7 → `gnt[0]` in cycle 1 with `ram_wr_en=1`, `ram_addr=7`, `ram_din=A5A5`; the RAM model holds A5A5 at address 7.
- Read-back: requester 1 reads address 7 with RD_LAT=1 → `gnt[1]` in cycle 1, `rvalid[1]` in cycle 3, `rdata=16'hA5A5`, `rvalid[0]` stays 0.
- Contention: both requesters keep requesting reads for 8 grants → grants alternate 0, 1, 0, 1, …, with no grant closer than 4 cycles apart (RD_LAT=1).
- Reset mid-read: assert `rst` during WAIT → next cycle is IDLE, no `rvalid` pulse; a subsequent read completes normally.
- Parity (macro defined): the RAM model returns 16'h0001 with `ram_parity=0` → `par_err=1` in the same cycle as `rvalid`; with correct parity, `par_err=0`.
